fixed_mult_q8_8: RTL and testbench

Sequential signed fixed-point multiplier: the inverse of the team's combinational Q8.8 divider. It computes out1 = sat((in1 × in2) >>> FRAC) with a shift-add datapath. It sits beside the divider in the noise-cancelling arithmetic path, for gain scaling and filter-coefficient application. Valid/ready handshakes on both sides let it be dropped between registered pipeline stages.

---
 rtl/fixed_pkg.sv | 13 +
 rtl/fixed_sat.sv | 25 ++
 rtl/fixed_mult_q8_8.sv | 123 ++++++++++++
 tb/tb_fixed_mult_q8_8.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_pkg.sv
// Shared fixed-point definitions for the Q8.8 arithmetic blocks (multiplier, divider, saturators).
package fixed_pkg;
   localparam int FIXED_WIDTH = 16;
   localparam int FIXED_FRAC  = 8;
   localparam int Q_MAX       = (1 << (FIXED_WIDTH - 1)) - 1;
   localparam int Q_MIN       = -(1 << (FIXED_WIDTH - 1));

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_e;
endpackage

// File: rtl/fixed_sat.sv
// Combinational saturator: narrows a (2*WIDTH+1)-bit signed value to WIDTH bits and flags clipping.
module fixed_sat
   import fixed_pkg::*;
#(
   parameter int WIDTH = FIXED_WIDTH
) (
   input  logic signed [2*WIDTH:0]  val_i,
   output logic signed [WIDTH-1:0]  sat_o,
   output logic                     ovf_o
);
   localparam logic signed [2*WIDTH:0] MAX_V = {{(WIDTH + 2){1'b0}}, {(WIDTH - 1){1'b1}}};
   localparam logic signed [2*WIDTH:0] MIN_V = {{(WIDTH + 2){1'b1}}, {(WIDTH - 1){1'b0}}};

   always_comb begin
      sat_o = val_i[WIDTH-1:0];
      ovf_o = 1'b0;
      if (val_i > MAX_V) begin
         sat_o = {1'b0, {(WIDTH - 1){1'b1}}};
         ovf_o = 1'b1;
      end else if (val_i < MIN_V) begin
         sat_o = {1'b1, {(WIDTH - 1){1'b0}}};
         ovf_o = 1'b1;
      end
   end
endmodule

// File: rtl/fixed_mult_q8_8.sv
// Sequential signed Q8.8 multiplier: sign/magnitude shift-add over WIDTH cycles, floor-shifted
// and saturated result presented behind a valid/ready handshake.
module fixed_mult_q8_8
   import fixed_pkg::*;
#(
   parameter int WIDTH = FIXED_WIDTH,
   parameter int FRAC  = FIXED_FRAC
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [WIDTH-1:0]  in1,
   input  logic signed [WIDTH-1:0]  in2,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [WIDTH-1:0]  out1,
   output logic                     ovf
);
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e                    state_q, state_d;
   logic                      sign_q, sign_d;
   logic [2*WIDTH-1:0]        mcand_q, mcand_d;
   logic [WIDTH-1:0]          mplier_q, mplier_d;
   logic [2*WIDTH-1:0]        acc_q, acc_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic signed [WIDTH-1:0]   out1_q, out1_d;
   logic                      ovf_q, ovf_d;

   logic [WIDTH-1:0]          mag1, mag2;
   logic [2*WIDTH-1:0]        acc_sum;
   logic signed [2*WIDTH:0]   prod;
   logic signed [2*WIDTH:0]   prod_shr;
   logic signed [WIDTH-1:0]   sat_val;
   logic                      sat_ovf;

   // |-2^(WIDTH-1)| wraps to itself, which is the correct unsigned magnitude
   always_comb begin
      mag1     = in1[WIDTH-1] ? -in1 : in1;
      mag2     = in2[WIDTH-1] ? -in2 : in2;
      acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
      prod     = sign_q ? -$signed({1'b0, acc_sum}) : $signed({1'b0, acc_sum});
      prod_shr = prod >>> FRAC;
   end

   fixed_sat #(
      .WIDTH (WIDTH)
   ) u_sat (
      .val_i (prod_shr),
      .sat_o (sat_val),
      .ovf_o (sat_ovf)
   );

   always_comb begin
      state_d  = state_q;
      sign_d   = sign_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      out1_d   = out1_q;
      ovf_d    = ovf_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sign_d   = in1[WIDTH-1] ^ in2[WIDTH-1];
               mcand_d  = {{WIDTH{1'b0}}, mag1};
               mplier_d = mag2;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = BUSY;
            end
         end
         BUSY: begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            // Last iteration: the result is taken from the final sum in the same cycle
            if (cnt_q == CNT_LAST) begin
               out1_d  = sat_val;
               ovf_d   = sat_ovf;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         sign_q   <= 1'b0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         out1_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sign_q   <= sign_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         out1_q   <= out1_d;
         ovf_q    <= ovf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out1      = out1_q;
   assign ovf       = ovf_q;
endmodule

// File: tb/tb_fixed_mult_q8_8.sv
// Bench for fixed_mult_q8_8: directed corner products, backpressure, mid-operation reset and
// randomized back-to-back traffic against an integer reference of floor(a*b/256) with saturation.
module tb_fixed_mult_q8_8;
   import fixed_pkg::*;

   logic               clk;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic signed [15:0] in1;
   logic signed [15:0] in2;
   logic               out_valid;
   logic               out_ready;
   logic signed [15:0] out1;
   logic               ovf;

   int checks;
   int passes;

   fixed_mult_q8_8 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in1       (in1),
      .in2       (in2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out1      (out1),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void ref_mult(input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] r, output logic o);
      longint p;
      longint q;
      p = longint'($signed(a)) * longint'($signed(b));
      q = p >>> 8;
      if (q > longint'(Q_MAX)) begin
         r = 16'h7FFF;
         o = 1'b1;
      end else if (q < longint'(Q_MIN)) begin
         r = 16'h8000;
         o = 1'b1;
      end else begin
         r = q[15:0];
         o = 1'b0;
      end
   endfunction

   function automatic logic [15:0] rand_op();
      case ($urandom_range(0, 5))
         0:       return 16'h8000;
         1:       return 16'h7FFF;
         2:       return 16'h0000;
         3:       return 16'($urandom_range(0, 511)) - 16'd256;
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one operation from IDLE with out_ready low and waits for out_valid.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] r, output logic o, output int lat);
      in1      = a;
      in2      = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
      end
      r = out1;
      o = ovf;
   endtask

   task automatic finish_op();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready); else passes++;
      checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid); else passes++;
      checks++; if (out1 !== 16'h0000) $display("FAIL reset_out1 got=%h want=0000", out1); else passes++;
      checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf got=%b want=0", ovf); else passes++;
      rst_n = 1'b1;
      tick();
      checks++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready got=%b want=1", in_ready); else passes++;
   endtask

   task automatic test_directed();
      logic [15:0] va [8] = '{16'h0180, 16'hFE80, 16'h0001, 16'h0001,
                              16'h7FFF, 16'h8000, 16'h8000, 16'h8000};
      logic [15:0] vb [8] = '{16'h0200, 16'h0200, 16'hFFFF, 16'h0001,
                              16'h7FFF, 16'h7FFF, 16'h8000, 16'h0100};
      logic [15:0] vr [8] = '{16'h0300, 16'hFD00, 16'hFFFF, 16'h0000,
                              16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000};
      logic        vo [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [15:0] r;
      logic        o;
      int          lat;
      for (int i = 0; i < 8; i++) begin
         checks++; if (in_ready !== 1'b1) $display("FAIL dir%0d_in_ready got=%b want=1", i, in_ready); else passes++;
         run_op(va[i], vb[i], r, o, lat);
         checks++; if (lat !== 17) $display("FAIL dir%0d_latency got=%0d want=17", i, lat); else passes++;
         checks++; if (r !== vr[i]) $display("FAIL dir%0d_out1 %h*%h got=%h want=%h", i, va[i], vb[i], r, vr[i]); else passes++;
         checks++; if (o !== vo[i]) $display("FAIL dir%0d_ovf got=%b want=%b", i, o, vo[i]); else passes++;
         finish_op();
         checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL dir%0d_release out_valid=%b in_ready=%b want 0/1", i, out_valid, in_ready);
         else passes++;
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] er;
      logic        eo;
      int          n;
      ref_mult(16'hFE80, 16'h0300, er, eo);
      in1      = 16'hFE80;
      in2      = 16'h0300;
      in_valid = 1'b1;
      tick();
      n = 1;
      while (!out_valid && n < 100) begin
         in_valid = 1'($urandom);
         in1      = 16'($urandom);
         in2      = 16'($urandom);
         tick();
         n++;
      end
      checks++; if (n !== 17) $display("FAIL bp_latency got=%0d want=17", n); else passes++;
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'($urandom);
         in1      = 16'($urandom);
         in2      = 16'($urandom);
         checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL bp_hold%0d out_valid=%b in_ready=%b want 1/0", k, out_valid, in_ready);
         else passes++;
         checks++; if (out1 !== er || ovf !== eo)
            $display("FAIL bp_stable%0d out1=%h ovf=%b want %h/%b", k, out1, ovf, er, eo);
         else passes++;
         tick();
      end
      in_valid = 1'b0;
      finish_op();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL bp_release out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
      else passes++;
   endtask

   task automatic test_reset_mid_op();
      logic [15:0] r;
      logic        o;
      int          lat;
      in1      = 16'h7FFF;
      in2      = 16'h0100;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 6; k++) tick();
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || out1 !== 16'h0000 || ovf !== 1'b0)
         $display("FAIL midrst_outputs out_valid=%b out1=%h ovf=%b want 0/0000/0", out_valid, out1, ovf);
      else passes++;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
         $display("FAIL midrst_release in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
      else passes++;
      run_op(16'h0100, 16'h0300, r, o, lat);
      checks++; if (lat !== 17) $display("FAIL midrst_next_latency got=%0d want=17", lat); else passes++;
      checks++; if (r !== 16'h0300 || o !== 1'b0)
         $display("FAIL midrst_next_result out1=%h ovf=%b want 0300/0", r, o);
      else passes++;
      finish_op();
   endtask

   task automatic test_back_to_back();
      localparam int N      = 1000;
      localparam int BUDGET = 40000;
      logic [15:0] qa [$];
      logic [15:0] qb [$];
      logic [15:0] er;
      logic        eo;
      logic [15:0] ea;
      logic [15:0] eb;
      logic        fire_in;
      logic        fire_out;
      int          issued = 0;
      int          done_cnt = 0;
      int          cyc = 0;
      in1      = rand_op();
      in2      = rand_op();
      in_valid = 1'b1;
      while (done_cnt < N && cyc < BUDGET) begin
         out_ready = 1'($urandom);
         fire_out  = out_valid && out_ready;
         fire_in   = in_valid && in_ready;
         if (fire_out) begin
            if (qa.size() == 0) begin
               checks++;
               $display("FAIL b2b_unexpected_result out1=%h with no operation pending", out1);
            end else begin
               ea = qa.pop_front();
               eb = qb.pop_front();
               ref_mult(ea, eb, er, eo);
               checks++; if (out1 !== er || ovf !== eo)
                  $display("FAIL b2b_result %h*%h got=%h/%b want=%h/%b", ea, eb, out1, ovf, er, eo);
               else passes++;
            end
            done_cnt++;
         end
         if (fire_in) begin
            qa.push_back(in1);
            qb.push_back(in2);
            issued++;
         end
         tick();
         cyc++;
         if (fire_in) begin
            if (issued < N) begin
               in1 = rand_op();
               in2 = rand_op();
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      checks++; if (done_cnt !== N)
         $display("FAIL b2b_completion got=%0d results want=%0d within %0d cycles", done_cnt, N, BUDGET);
      else passes++;
   endtask

   initial begin
      checks    = 0;
      passes    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in1       = '0;
      in2       = '0;
      out_ready = 1'b0;
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid_op();
      test_back_to_back();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
